// File: rtl/ssd_scan_sched.sv
// Seven-segment scan sequencer: dwell-rate digit index, per-slot blank window, frame-synchronous display commit.
// Latency: clk_ctl/blank/in0..in3 registered, frame_tick combinational; upd_ready low while a word waits for the frame boundary.
module ssd_scan_sched #(
  parameter int DIV_W = 16,
  parameter int DWELL = 50000,
  parameter int BLANK = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_valid,
  input  logic [15:0]      upd_data,
  output logic             upd_ready,
  input  logic [3:0]       digit_en,
  output logic [1:0]       clk_ctl,
  output logic [3:0]       in0,
  output logic [3:0]       in1,
  output logic [3:0]       in2,
  output logic [3:0]       in3,
  output logic             blank,
  output logic             frame_tick
);

  localparam logic [DIV_W-1:0] LAST    = DIV_W'(DWELL - 1);
  localparam logic [DIV_W-1:0] BLANK_N = DIV_W'(BLANK);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [1:0]       ctl_nxt;
  logic             wrap;
  logic             blank_r;
  logic             blank_nxt;
  logic             first_r;
  logic [15:0]      pending;
  logic             pending_full;

  // blank is computed one cycle ahead from the next cnt/clk_ctl so the
  // registered value lines up exactly with the slot it gates.
  always_comb begin
    wrap      = (cnt == LAST);
    cnt_nxt   = wrap ? '0 : cnt + DIV_W'(1);
    ctl_nxt   = wrap ? clk_ctl + 2'd1 : clk_ctl;
    blank_nxt = (cnt_nxt < BLANK_N) | ~digit_en[ctl_nxt];
  end

  assign frame_tick = (clk_ctl == 2'd3) && wrap;
  assign upd_ready  = ~pending_full;

  // With no blank window the first post-reset cycle follows digit 0's enable directly.
  assign blank = (BLANK == 0 && first_r) ? ~digit_en[0] : blank_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      clk_ctl      <= 2'd0;
      blank_r      <= 1'b1;
      first_r      <= 1'b1;
      in0          <= 4'd0;
      in1          <= 4'd0;
      in2          <= 4'd0;
      in3          <= 4'd0;
      pending      <= 16'd0;
      pending_full <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      clk_ctl <= ctl_nxt;
      blank_r <= blank_nxt;
      first_r <= 1'b0;
      if (frame_tick && pending_full) begin
        {in0, in1, in2, in3} <= pending;
        pending_full         <= 1'b0;
      end else if (upd_valid && upd_ready) begin
        pending      <= upd_data;
        pending_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_sched.sv
// Directed bench for ssd_scan_sched (DWELL=8, BLANK=2) with a cycle-indexed reference model.
module tb_ssd_scan_sched;
  localparam int D = 8;
  localparam int B = 2;
  localparam int F = 4 * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = 16'd0;
  logic        upd_ready;
  logic [3:0]  digit_en = 4'hF;
  logic [1:0]  clk_ctl;
  logic [3:0]  in0, in1, in2, in3;
  logic        blank;
  logic        frame_tick;

  ssd_scan_sched #(.DIV_W(16), .DWELL(D), .BLANK(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_valid  (upd_valid),
    .upd_data   (upd_data),
    .upd_ready  (upd_ready),
    .digit_en   (digit_en),
    .clk_ctl    (clk_ctl),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .blank      (blank),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int t       = 0;
  int phase   = 0;

  // Reference state: what is on the display, what is waiting, last cycle's enables.
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_full;
  logic [3:0]  en_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s phase=%0d t=%0d: got %0h expected %0h", name, phase, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    m_disp  = 16'd0;
    m_pend  = 16'd0;
    m_full  = 1'b0;
    en_prev = 4'hF;
  endtask

  task automatic model_check();
    int slot;
    int c;
    slot = (t / D) % 4;
    c    = t % D;
    chk("clk_ctl",    32'(clk_ctl),    32'(slot));
    chk("blank",      32'(blank),      32'((c < B) || !en_prev[slot]));
    chk("frame_tick", 32'(frame_tick), 32'((t % F) == F - 1));
    chk("upd_ready",  32'(upd_ready),  32'(!m_full));
    chk("display",    32'({in0, in1, in2, in3}), 32'(m_disp));
  endtask

  task automatic model_advance();
    if ((t % F) == F - 1 && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end else if (upd_valid && !m_full) begin
      m_pend = upd_data;
      m_full = 1'b1;
    end
    en_prev = digit_en;
    t++;
  endtask

  // Hand-computed expectations that pin the model to the written behaviour.
  task automatic pin();
    logic [15:0] d;
    d = {in0, in1, in2, in3};
    if (phase == 1) begin
      case (t)
        0:   begin chk("p_ctl0", 32'(clk_ctl), 0); chk("p_blank0", 32'(blank), 1); end
        2:   chk("p_blank_show", 32'(blank), 0);
        5:   chk("p_ready5", 32'(upd_ready), 1);
        6:   chk("p_ready6", 32'(upd_ready), 0);
        8:   chk("p_ctl8", 32'(clk_ctl), 1);
        30:  chk("p_tick30", 32'(frame_tick), 0);
        31:  begin chk("p_tick31", 32'(frame_tick), 1); chk("p_ctl31", 32'(clk_ctl), 3); chk("p_disp31", 32'(d), 0); end
        32:  begin chk("p_disp32", 32'(d), 32'h1234); chk("p_ready32", 32'(upd_ready), 1); chk("p_ctl32", 32'(clk_ctl), 0); end
        33:  chk("p_ready33", 32'(upd_ready), 0);
        63:  chk("p_disp63", 32'(d), 32'h1234);
        64:  chk("p_disp64", 32'(d), 32'hABCD);
        96:  begin chk("p_disp96", 32'(d), 32'hABCD); chk("p_ready96", 32'(upd_ready), 0); end
        127: chk("p_disp127", 32'(d), 32'hABCD);
        128: chk("p_disp128", 32'(d), 32'h5678);
        130: chk("p_blank_slot0", 32'(blank), 1);
        137: chk("p_blank_slot1_win", 32'(blank), 1);
        138: chk("p_blank_slot1_show", 32'(blank), 0);
        146: chk("p_blank_slot2", 32'(blank), 1);
        154: chk("p_blank_slot3_show", 32'(blank), 0);
        default: ;
      endcase
    end else if (phase == 2) begin
      case (t)
        31: chk("p2_tick31", 32'(frame_tick), 1);
        32: begin chk("p2_disp32", 32'(d), 0); chk("p2_ready32", 32'(upd_ready), 1); end
        40: chk("p2_ctl40", 32'(clk_ctl), 1);
        default: ;
      endcase
    end
  endtask

  task automatic drive();
    if (phase == 1) begin
      upd_valid = (t >= 5 && t <= 32) || t == 95 || t == 165;
      if (t == 5)       upd_data = 16'h1234;
      else if (t <= 32) upd_data = 16'hABCD;
      else if (t == 95) upd_data = 16'h5678;
      else              upd_data = 16'h9999;
      digit_en = (t >= 127 && t < 160) ? 4'b1010 : 4'b1111;
    end else begin
      upd_valid = 1'b0;
      upd_data  = 16'hFFFF;
      digit_en  = 4'b1111;
    end
  endtask

  task automatic cycle();
    model_check();
    pin();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl",   32'(clk_ctl), 0);
    chk("rst_disp",  32'({in0, in1, in2, in3}), 0);
    chk("rst_blank", 32'(blank), 1);
    chk("rst_tick",  32'(frame_tick), 0);
    chk("rst_ready", 32'(upd_ready), 1);

    rst_n = 1'b1;
    model_reset();
    phase = 1;
    for (int i = 0; i < 180; i++) begin
      drive();
      cycle();
    end

    // Mid-slot-2 reset with 16'h9999 still pending.
    chk("pre_rst_ctl",   32'(clk_ctl), 2);
    chk("pre_rst_disp",  32'({in0, in1, in2, in3}), 32'h5678);
    chk("pre_rst_ready", 32'(upd_ready), 0);
    upd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_ctl",   32'(clk_ctl), 0);
    chk("async_disp",  32'({in0, in1, in2, in3}), 0);
    chk("async_ready", 32'(upd_ready), 1);
    chk("async_blank", 32'(blank), 1);
    chk("async_tick",  32'(frame_tick), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    phase = 2;
    for (int i = 0; i < 70; i++) begin
      drive();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_sched.md
Name: ssd_scan_sched

Overview:
- Sequencer for the 4-digit seven-segment scan multiplexer.
- Generates the 2-bit digit-select index (`clk_ctl`) at a programmable dwell rate.
- Inserts an anti-ghosting blank window at the start of every digit slot.
- Holds the four displayed nibbles in a double buffer. New values are accepted over a valid/ready handshake and committed only at a frame boundary, so the display never tears mid-scan.
- Outputs drive the scan mux's `clk_ctl`, `in0`..`in3` and an external blank gate on the digit enables.

Parameters:
- DIV_W, 16, width of the dwell counter.
- DWELL, 50000, clock cycles per digit slot (legal range 2..2^DIV_W-1).
- BLANK, 500, cycles at the start of each slot with `blank` asserted (legal range 0..DWELL-1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- upd_valid  input  1  new display word offered
- upd_data  input  16  nibbles {digit0, digit1, digit2, digit3}; [15:12] goes to digit0
- upd_ready  output  1  pending buffer free; a transfer occurs when upd_valid and upd_ready are both high
- digit_en  input  4  per-digit enable, bit i = digit i; 0 forces blank during that slot
- clk_ctl  output  2  current digit index, goes to the scan mux
- in0  output  4  committed nibble for digit 0
- in1  output  4  committed nibble for digit 1
- in2  output  4  committed nibble for digit 2
- in3  output  4  committed nibble for digit 3
- blank  output  1  1 = all digit enables forced inactive this cycle
- frame_tick  output  1  one-cycle pulse at the frame boundary (last cycle of slot 3)

Behaviour:
- Reset (asynchronous on rst_n low; all registers):
  - cnt = 0, clk_ctl = 0, in0..in3 = 0.
  - pending_full = 0, pending = 0.
  - frame_tick = 0, upd_ready = 1.
  - blank = 1 if BLANK > 0, else blank = ~digit_en[0].
- Dwell counter:
  - cnt increments by 1 each clock.
  - When cnt == DWELL-1: cnt wraps to 0 and clk_ctl increments modulo 4 (3 wraps to 0).
  - Every slot lasts exactly DWELL cycles; a full frame lasts 4*DWELL cycles.
- Per-slot phases, decoded from cnt (no separate state register needed):
  - BLANK phase: cnt < BLANK. blank = 1.
  - SHOW phase: cnt >= BLANK. blank = ~digit_en[clk_ctl].
  - blank is a registered output aligned with the current cnt/clk_ctl. It may be decoded from the registered values, but must be glitch-free relative to clk_ctl.
- frame_tick:
  - Combinational: 1 exactly when clk_ctl == 3 and cnt == DWELL-1.
  - Otherwise 0.
- Update handshake:
  - upd_ready = ~pending_full.
  - Transfer when upd_valid && upd_ready: pending <= upd_data, pending_full <= 1.
  - upd_data is ignored when no transfer occurs.
  - The source may hold upd_valid high. Data must stay stable until the transfer cycle.
- Commit:
  - On a frame_tick cycle with pending_full = 1: {in0,in1,in2,in3} <= pending and pending_full <= 0.
  - The new values appear in the same clock edge that moves clk_ctl from 3 to 0, so every frame shows one coherent word.
- Simultaneous events:
  - Commit and accept in the same cycle cannot both happen: upd_ready is 0 whenever pending_full is 1.
  - upd_ready rises the cycle after the commit.
  - A transfer on a frame_tick cycle when pending was empty is not committed in that cycle; it waits for the next frame boundary.
- digit_en changes take effect on the next cycle's blank; they do not affect counting.
- Reset mid-frame:
  - Any pending word is discarded.
  - The display returns to 0000 and scanning restarts at digit 0 with cnt = 0.
- No combinational path from upd_valid to upd_ready.

Test Plan (DWELL=8, BLANK=2):
- Reset release, digit_en=1111, no updates:
  - clk_ctl sequences 0,0..(8 cycles),1,...,3, then back to 0.
  - blank high for cnt 0-1 of each slot, low for cnt 2-7.
  - frame_tick pulses exactly once per 32 cycles, on cnt=7 of slot 3.
  - in0..in3 remain 0.
- upd_valid=1, upd_data=16'h1234 at cycle 5 after reset:
  - Transfer at cycle 5; upd_ready low from cycle 6.
  - in0=1, in1=2, in2=3, in3=4 appear on the edge ending cycle 31 (first frame_tick).
  - upd_ready high again at cycle 32.
- Second word 16'hABCD offered while pending full:
  - Held off, with upd_ready = 0.
  - Accepted the cycle after commit of the first word.
  - Displayed only after the following frame_tick; no torn frame in between.
- Word accepted on the frame_tick cycle itself with pending empty:
  - Not committed at that boundary.
  - Committed at the next boundary, 32 cycles later.
- digit_en=1010:
  - blank stays 1 for the entire slot when clk_ctl = 0 and when clk_ctl = 2.
  - In slots 1 and 3, blank follows the normal 2-high / 6-low pattern.
- rst_n pulsed low mid-slot 2 with a word pending:
  - Outputs return to reset values immediately (asynchronously).
  - After release: pending discarded, upd_ready=1, clk_ctl=0, cnt restarts at 0.
